// File: rtl/column_window_feeder.sv
// column_window_feeder
//   Turns a raster 8-bit grayscale pixel stream into one 56-bit vertical
//   column per accepted pixel. A column holds the 7 most recent rows at the
//   current x. The current pixel is in the top byte and the oldest row is in
//   the bottom byte. Six line buffers of WIDTH pixels hold the previous rows.
//
// Ports
//   i_clk    : single rising-edge clock
//   i_rst    : synchronous active-high reset (priority over everything)
//   i_valid  : i_pixel is valid this cycle (always accepted)
//   i_sof    : with i_valid, forces the pixel to position (0,0)
//   i_pixel  : 8-bit pixel, raster order
//   o_valid  : one-cycle pulse, o_col/o_x/o_y carry a column
//   o_col    : [55:48] row y (current) ... [7:0] row y-6
//   o_x      : column x
//   o_y      : centre row index (y-3)
//   o_eol    : with o_valid, column is the last of its line
//   o_eof    : with o_valid, column is the last of the frame
module column_window_feeder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_pixel,
  output logic        o_valid,
  output logic [55:0] o_col,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_eol,
  output logic        o_eof
);

  localparam int          AW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [11:0] X_LAST    = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST    = 12'(HEIGHT - 1);
  localparam logic [11:0] FILL_ROWS = 12'd6;

  logic [11:0]     x_r;
  logic [11:0]     y_r;
  logic [11:0]     cur_x_s;
  logic [11:0]     cur_y_s;
  logic [11:0]     nxt_x_s;
  logic [11:0]     nxt_y_s;
  logic            emit_s;
  logic [AW-1:0]   addr_s;
  // col_s[6] is the incoming pixel; col_s[5-k] is the old content of line k.
  // Line k is written with col_s[6-k], which gives the L5<=L4 ... L0<=p shift.
  logic [6:0][7:0] col_s;

  assign col_s[6] = i_pixel;
  assign addr_s   = cur_x_s[AW-1:0];

  genvar k;
  generate
    for (k = 0; k < 6; k++) begin : g_line
      logic [7:0] mem_r [0:WIDTH-1];

      // Asynchronous read of the old data, so the column sees the pre-write value.
      assign col_s[5-k] = mem_r[addr_s];

      // Line buffer write. The contents are not reset because the fill gate masks them.
      always_ff @(posedge i_clk) begin
        if (i_valid && !i_rst) begin
          mem_r[addr_s] <= col_s[6-k];
        end
      end
    end
  endgenerate

  // Position of the pixel being accepted (a start-of-frame marker forces 0,0) and the following position.
  always_comb begin
    cur_x_s = x_r;
    cur_y_s = y_r;
    nxt_x_s = 12'd0;
    nxt_y_s = 12'd0;
    if (i_sof) begin
      cur_x_s = 12'd0;
      cur_y_s = 12'd0;
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
    end
    if (cur_x_s == X_LAST) begin
      nxt_x_s = 12'd0;
      if (cur_y_s == Y_LAST) begin
        nxt_y_s = 12'd0;
      end else begin
        nxt_y_s = cur_y_s + 12'd1;
      end
    end else begin
      nxt_x_s = cur_x_s + 12'd1;
      nxt_y_s = cur_y_s;
    end
    emit_s = (cur_y_s >= FILL_ROWS);
  end

  // Position counters and the registered column outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_r     <= 12'd0;
      y_r     <= 12'd0;
      o_valid <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      o_col   <= 56'd0;
      o_x     <= 12'd0;
      o_y     <= 12'd0;
    end else if (i_valid) begin
      x_r     <= nxt_x_s;
      y_r     <= nxt_y_s;
      o_valid <= emit_s;
      o_eol   <= emit_s && (cur_x_s == X_LAST);
      o_eof   <= emit_s && (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
      o_col   <= col_s;
      o_x     <= cur_x_s;
      o_y     <= cur_y_s - 12'd3;
    end else begin
      o_valid <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_column_window_feeder.sv
// tb_column_window_feeder
//   Directed bench for column_window_feeder with an 8x8 frame. It uses ramp
//   frames, pixel streams with gaps, back-to-back frames, a mid-line
//   start-of-frame resync and a mid-frame reset. Expected columns come from a
//   bench-side image of the rows sent in the current frame.
module tb_column_window_feeder;

  localparam int W = 8;
  localparam int H = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_sof;
  logic [7:0]  i_pixel;
  logic        o_valid;
  logic [55:0] o_col;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_eol;
  logic        o_eof;

  column_window_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_sof  (i_sof),
    .i_pixel(i_pixel),
    .o_valid(o_valid),
    .o_col  (o_col),
    .o_x    (o_x),
    .o_y    (o_y),
    .o_eol  (o_eol),
    .o_eof  (o_eof)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  hist [0:H-1][0:W-1];
  logic [11:0] mx;
  logic [11:0] my;
  bit          known;
  logic [55:0] lcol;
  logic [11:0] lx;
  logic [11:0] ly;
  int          ncol;
  int          neol;
  int          neof;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mx    = 12'd0;
    my    = 12'd0;
    known = 1'b0;
  endtask

  task automatic clear_counts();
    ncol = 0;
    neol = 0;
    neof = 0;
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic step(input bit v, input bit sof, input logic [7:0] p);
    logic [11:0] ex;
    logic [11:0] ey;
    logic [55:0] ec;
    bit          ev;
    @(negedge i_clk);
    i_valid = v;
    i_sof   = sof;
    i_pixel = p;
    @(posedge i_clk);
    #1;
    if (v) begin
      ex = sof ? 12'd0 : mx;
      ey = sof ? 12'd0 : my;
      ev = (ey >= 12'd6);
      ec = 56'd0;
      ec[55:48] = p;
      if (ev) begin
        for (int r = 1; r <= 6; r++) begin
          ec[55 - 8*r -: 8] = hist[ey - 12'(r)][ex];
        end
      end
      hist[ey][ex] = p;
      if (ex == 12'(W - 1)) begin
        mx = 12'd0;
        my = (ey == 12'(H - 1)) ? 12'd0 : ey + 12'd1;
      end else begin
        mx = ex + 12'd1;
        my = ey;
      end
      check_val("valid", 64'(o_valid), 64'(ev));
      check_val("eol", 64'(o_eol), 64'(ev && ex == 12'(W - 1)));
      check_val("eof", 64'(o_eof), 64'(ev && ex == 12'(W - 1) && ey == 12'(H - 1)));
      if (ev) begin
        check_val("col", 64'(o_col), 64'(ec));
        check_val("x", 64'(o_x), 64'(ex));
        check_val("y", 64'(o_y), 64'(ey - 12'd3));
        known = 1'b1;
        lcol  = ec;
        lx    = ex;
        ly    = ey - 12'd3;
      end else begin
        known = 1'b0;
      end
    end else begin
      check_val("idle_valid", 64'(o_valid), 64'd0);
      check_val("idle_eol", 64'(o_eol), 64'd0);
      if (known) begin
        check_val("hold_col", 64'(o_col), 64'(lcol));
        check_val("hold_x", 64'(o_x), 64'(lx));
        check_val("hold_y", 64'(o_y), 64'(ly));
      end
    end
    if (o_valid) ncol++;
    if (o_valid && o_eol) neol++;
    if (o_valid && o_eof) neof++;
  endtask

  // Send npix ramp pixels (base + raster index), optionally with idle gaps.
  task automatic frame(input int base, input bit gaps, input bit sof, input int npix);
    logic [55:0] first;
    for (int i = 0; i < npix; i++) begin
      step(1'b1, sof && (i == 0), 8'(base + i));
      if (i == 48) begin
        first = {8'(base + 48), 8'(base + 40), 8'(base + 32), 8'(base + 24),
                 8'(base + 16), 8'(base + 8), 8'(base)};
        check_val("first_col", 64'(o_col), 64'(first));
        check_val("first_x", 64'(o_x), 64'd0);
        check_val("first_y", 64'(o_y), 64'd3);
      end
      if (gaps) step(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_ncol"}, 64'(ncol), 64'd16);
    check_val({tag, "_neol"}, 64'(neol), 64'd2);
    check_val({tag, "_neof"}, 64'(neof), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 64'(o_valid), 64'd0);
    check_val({tag, "_col"}, 64'(o_col), 64'd0);
    check_val({tag, "_x"}, 64'(o_x), 64'd0);
    check_val({tag, "_y"}, 64'(o_y), 64'd0);
    check_val({tag, "_eol"}, 64'(o_eol), 64'd0);
    check_val({tag, "_eof"}, 64'(o_eof), 64'd0);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_pixel = 8'h00;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_zero("rst");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Continuous ramp frame.
    clear_counts();
    frame(0, 1'b0, 1'b1, 64);
    check_val("s1_lastcol", 64'(o_col), 64'h3f37_2f27_1f17_0f);
    check_counts("s1");

    // The same frame with an idle cycle after every pixel.
    clear_counts();
    frame(0, 1'b1, 1'b1, 64);
    check_counts("s2");

    // Two back-to-back frames. The second frame's columns hold only its own data.
    frame(0, 1'b0, 1'b1, 64);
    clear_counts();
    frame(8'h80, 1'b0, 1'b1, 64);
    check_counts("s3");

    // Start-of-frame marker in the middle of line 7, at x=3.
    frame(0, 1'b0, 1'b1, 59);
    clear_counts();
    frame(8'h80, 1'b0, 1'b1, 64);
    check_counts("s4");

    // Reset mid-frame at (5,7) while the DUT is producing columns. i_valid is high.
    frame(0, 1'b0, 1'b1, 61);
    check_val("s5_pre_valid", 64'(o_valid), 64'd1);
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    i_pixel = 8'h55;
    @(posedge i_clk);
    #1;
    check_zero("s5_rst");
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    model_reset();
    clear_counts();
    frame(0, 1'b0, 1'b0, 64);
    check_counts("s5");

    @(negedge i_clk);
    i_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
